// File: rtl/op_pkg.sv
// Shared opcode set, word-layout helpers and sequencer state encoding for the
// fixed-point operation machine and its program sequencer.
package op_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LD1  = 3'b001;
  localparam logic [2:0] OP_LD2  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_MULT = 3'b100;
  localparam logic [2:0] OP_NEG  = 3'b101;
  localparam logic [2:0] OP_ABS  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  // Width of one machine index field for a given stack depth.
  function automatic int unsigned idx_w(input int unsigned stack_depth);
    return int'($clog2(stack_depth)) + 2;
  endfunction

  // Instruction word width: opcode, three indices, value.
  function automatic int unsigned instr_w(input int unsigned n, input int unsigned stack_depth);
    return 3 + 3 * idx_w(stack_depth) + n;
  endfunction

  // Arithmetic opcodes need the machine's registered operand path to settle.
  function automatic logic is_arith(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_ABS);
  endfunction

endpackage

// File: rtl/op_sequencer.sv
// Program sequencer: stores a small instruction program and replays it onto
// the operation machine inputs, holding arithmetic ops for ARITH_HOLD cycles.
module op_sequencer
  import op_pkg::*;
#(
  parameter  int unsigned N          = 32,
  parameter  int unsigned Q          = 16,
  parameter  int unsigned stack      = 5,
  parameter  int unsigned PROG_DEPTH = 16,
  parameter  int unsigned ARITH_HOLD = 2,
  localparam int unsigned PC_W       = $clog2(PROG_DEPTH),
  localparam int unsigned IDX_W      = idx_w(stack),
  localparam int unsigned INSTR_W    = instr_w(N, stack)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  output logic [2:0]         operand,
  output logic [IDX_W-1:0]   index1,
  output logic [IDX_W-1:0]   index2,
  output logic [IDX_W-1:0]   index3,
  output logic [N-1:0]       value,
  output logic               busy,
  output logic               done,
  output logic [PC_W-1:0]    pc
);

  localparam int unsigned    CNT_W    = (ARITH_HOLD > 1) ? $clog2(ARITH_HOLD) : 1;
  localparam logic [PC_W-1:0]  LAST_PC  = PC_W'(PROG_DEPTH - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(ARITH_HOLD - 1);

  // Reject parameter sets the machine cannot use.
  if (ARITH_HOLD < 1 || Q >= N) begin : g_param_check
    $error("op_sequencer: ARITH_HOLD must be >= 1 and Q must be < N");
  end

  logic [INSTR_W-1:0] r_mem [PROG_DEPTH];

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [PC_W-1:0]    w_pc_inc;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic [2:0]         w_first_op;
  logic [2:0]         w_cur_op;
  logic [2:0]         w_nxt_op;
  logic [INSTR_W-1:0] w_slot;

  logic [2:0]         w_operand_nxt;
  logic [IDX_W-1:0]   w_index1_nxt;
  logic [IDX_W-1:0]   w_index2_nxt;
  logic [IDX_W-1:0]   w_index3_nxt;
  logic [N-1:0]       w_value_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_first_op = r_mem[0][2:0];
  assign w_cur_op   = r_mem[r_pc][2:0];
  assign w_nxt_op   = r_mem[w_pc_inc][2:0];
  assign w_slot     = r_mem[w_pc_nxt];
  assign pc         = r_pc;

  // Program memory: writable only while no program is executing; kept across reset.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  // Next state, next pc/hold count and the registered-output values they imply.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_cnt_nxt     = '0;
    w_operand_nxt = OP_NOP;
    w_index1_nxt  = '0;
    w_index2_nxt  = '0;
    w_index3_nxt  = '0;
    w_value_nxt   = '0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pc_nxt    = '0;
          w_state_nxt = (w_first_op == OP_HALT) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE, S_HOLD: begin
        if (is_arith(w_cur_op) && (r_cnt < HOLD_MAX)) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end else if (r_pc == LAST_PC) begin
          w_state_nxt = S_DONE;
        end else begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = (w_nxt_op == OP_HALT) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_state_nxt == S_ISSUE || w_state_nxt == S_HOLD) begin
      w_operand_nxt = w_slot[2:0];
      w_index1_nxt  = w_slot[3 +: IDX_W];
      w_index2_nxt  = w_slot[3 + IDX_W +: IDX_W];
      w_index3_nxt  = w_slot[3 + 2 * IDX_W +: IDX_W];
      w_value_nxt   = w_slot[3 + 3 * IDX_W +: N];
      w_busy_nxt    = 1'b1;
    end
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State, pc, hold counter and all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      operand <= '0;
      index1  <= '0;
      index2  <= '0;
      index3  <= '0;
      value   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      operand <= w_operand_nxt;
      index1  <= w_index1_nxt;
      index2  <= w_index2_nxt;
      index3  <= w_index3_nxt;
      value   <= w_value_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: directed and random programs compared cycle by cycle
// against an expected trace expanded from the program contents.
module tb_op_sequencer;

  localparam int unsigned HOLD = 2;

  logic        clk;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [49:0] prog_data;
  logic        start;
  logic [2:0]  operand;
  logic [4:0]  index1;
  logic [4:0]  index2;
  logic [4:0]  index3;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic [3:0]  pc;

  op_sequencer #(
    .N(32), .Q(16), .stack(5), .PROG_DEPTH(16), .ARITH_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .operand(operand),
    .index1(index1), .index2(index2), .index3(index3), .value(value),
    .busy(busy), .done(done), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  i1;
    logic [4:0]  i2;
    logic [4:0]  i3;
    logic [31:0] val;
  } instr_t;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  i1;
    logic [4:0]  i2;
    logic [4:0]  i3;
    logic [31:0] val;
    logic        busy;
    logic        done;
    logic        chk_pc;
    logic [3:0]  pc;
  } exp_t;

  instr_t prog [16];
  exp_t   expq [$];
  int     n_assert = 0;
  int     n_fail   = 0;

  function automatic logic [49:0] encode(input instr_t x);
    return {x.val, x.i3, x.i2, x.i1, x.op};
  endfunction

  function automatic void set_slot(input int s, input logic [2:0] op, input logic [4:0] i1,
                                   input logic [4:0] i2, input logic [4:0] i3, input logic [31:0] val);
    prog[s].op  = op;
    prog[s].i1  = i1;
    prog[s].i2  = i2;
    prog[s].i3  = i3;
    prog[s].val = val;
  endfunction

  function automatic void rand_prog(input int max_op);
    for (int s = 0; s < 16; s++) begin
      set_slot(s, 3'($urandom_range(0, max_op)), 5'($urandom), 5'($urandom),
               5'($urandom), $urandom);
    end
  endfunction

  // Expected per-cycle trace: each slot shown for its length, then a done cycle, then idle.
  function automatic void build_expect();
    exp_t e;
    int   len;
    expq.delete();
    for (int s = 0; s < 16; s++) begin
      if (prog[s].op == 3'd7) break;
      len      = (prog[s].op >= 3'd3) ? HOLD : 1;
      e.op     = prog[s].op;
      e.i1     = prog[s].i1;
      e.i2     = prog[s].i2;
      e.i3     = prog[s].i3;
      e.val    = prog[s].val;
      e.busy   = 1'b1;
      e.done   = 1'b0;
      e.chk_pc = 1'b1;
      e.pc     = 4'(s);
      for (int k = 0; k < len; k++) expq.push_back(e);
    end
    e.op = 3'd0; e.i1 = 5'd0; e.i2 = 5'd0; e.i3 = 5'd0; e.val = 32'd0;
    e.busy = 1'b0; e.done = 1'b1; e.chk_pc = 1'b0; e.pc = 4'd0;
    expq.push_back(e);
    e.done = 1'b0;
    expq.push_back(e);
  endfunction

  task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic cmp_entry(input exp_t e, input int cyc);
    check("operand", cyc, 32'(operand), 32'(e.op));
    check("index1",  cyc, 32'(index1),  32'(e.i1));
    check("index2",  cyc, 32'(index2),  32'(e.i2));
    check("index3",  cyc, 32'(index3),  32'(e.i3));
    check("value",   cyc, value,        e.val);
    check("busy",    cyc, 32'(busy),    32'(e.busy));
    check("done",    cyc, 32'(done),    32'(e.done));
    if (e.chk_pc) check("pc", cyc, 32'(pc), 32'(e.pc));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_operand"}, -1, 32'(operand), 32'd0);
    check({tag, "_index1"},  -1, 32'(index1),  32'd0);
    check({tag, "_index2"},  -1, 32'(index2),  32'd0);
    check({tag, "_index3"},  -1, 32'(index3),  32'd0);
    check({tag, "_value"},   -1, value,        32'd0);
    check({tag, "_busy"},    -1, 32'(busy),    32'd0);
    check({tag, "_done"},    -1, 32'(done),    32'd0);
    check({tag, "_pc"},      -1, 32'(pc),      32'd0);
  endtask

  task automatic load_prog();
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 4'(s);
      prog_data = encode(prog[s]);
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Start the program and compare every cycle; optionally poke writes/starts while busy.
  task automatic run_prog(input bit disturb);
    build_expect();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < expq.size(); i++) begin
      cmp_entry(expq[i], i);
      if (disturb && expq[i].busy) begin
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd3;
        prog_data = 50'({$urandom, $urandom});
      end else begin
        start   = 1'b0;
        prog_we = 1'b0;
      end
      @(negedge clk);
    end
    start   = 1'b0;
    prog_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 50'd0;
    #2;
    check_zero("reset_init");
    @(negedge clk);
    rst = 1'b0;

    // Two loads then HALT.
    rand_prog(7);
    set_slot(0, 3'b001, 5'd20, 5'd0, 5'd0, 32'h0001_8000);
    set_slot(1, 3'b001, 5'd24, 5'd0, 5'd0, 32'h0002_0000);
    set_slot(2, 3'b111, 5'd0, 5'd0, 5'd0, 32'd0);
    load_prog();
    run_prog(1'b0);

    // Arithmetic instruction held, then HALT.
    set_slot(0, 3'b011, 5'd12, 5'd20, 5'd12, 32'd0);
    set_slot(1, 3'b111, 5'd0, 5'd0, 5'd0, 32'd0);
    load_prog();
    run_prog(1'b0);

    // Sixteen nops with no HALT runs to the last slot.
    for (int s = 0; s < 16; s++) set_slot(s, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0);
    load_prog();
    run_prog(1'b0);

    // HALT in slot 0.
    rand_prog(7);
    set_slot(0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h1234_5678);
    load_prog();
    run_prog(1'b0);

    // Writes and starts while busy are ignored; rerun shows the program intact.
    rand_prog(6);
    load_prog();
    run_prog(1'b1);
    run_prog(1'b0);

    // Asynchronous reset mid-run at slot 2, then a clean replay.
    build_expect();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < expq.size(); i++) begin
      cmp_entry(expq[i], i);
      if (expq[i].chk_pc && expq[i].pc == 4'd2) break;
      @(negedge clk);
    end
    #1 rst = 1'b1;
    #1;
    check_zero("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("after_reset");
    run_prog(1'b0);

    // Random programs.
    for (int t = 0; t < 15; t++) begin
      rand_prog(7);
      load_prog();
      run_prog(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
